core_dout_tx: RTL

- Core-side transmitter for the core result-output interface (core_dout_en / core_dout / seq_num / ctx_num).
- Buffers one 8-word result per context (2 slots) as the SHA-256 core produces it.
- Streams each completed slot to the shared memory writer as an 8-beat burst; data lags enable by one cycle.
- Honours a per-cycle downstream ready, so enable may have gaps.

---
 rtl/core_dout_tx_if.sv | 26 ++
 rtl/core_dout_tx.sv | 125 ++++++++++++
 2 files changed

// File: rtl/core_dout_tx_if.sv
// Result-output bus between the SHA-256 core side (fill) and the shared memory writer (burst).
// The slave modport is the transmitter's view; the master modport is the environment's view.
interface core_dout_tx_if;
    logic        in_wr_en;
    logic [31:0] in_din;
    logic        in_ctx_num;
    logic        in_seq_num;
    logic [1:0]  in_full;
    logic        tx_ready;
    logic        dout_en;
    logic [31:0] dout;
    logic        dout_seq_num;
    logic        dout_ctx_num;
    logic        busy;
    logic        err;

    modport slave (
        input  in_wr_en, in_din, in_ctx_num, in_seq_num, tx_ready,
        output in_full, dout_en, dout, dout_seq_num, dout_ctx_num, busy, err
    );

    modport master (
        output in_wr_en, in_din, in_ctx_num, in_seq_num, tx_ready,
        input  in_full, dout_en, dout, dout_seq_num, dout_ctx_num, busy, err
    );
endinterface

// File: rtl/core_dout_tx.sv
// Core-side result transmitter: buffers one N_WORDS result per context (2 slots) and
// streams each full slot to the memory writer as a burst, data one cycle behind enable.
module core_dout_tx #(
    parameter int N_WORDS = 8,
    parameter int CNT_MSB = 2
) (
    input  logic         CLK,
    input  logic         reset,
    core_dout_tx_if.slave bus
);
    typedef logic [CNT_MSB:0] cnt_t;
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    localparam cnt_t LAST = cnt_t'(N_WORDS - 1);

    state_t      state;
    logic [31:0] mem [2][N_WORDS];
    cnt_t        wr_cnt [2];
    logic [1:0]  full;
    logic [1:0]  seq_lat;
    cnt_t        rd_cnt;
    cnt_t        rd_idx;
    logic        rd_pend;
    logic        slot;
    logic        prio;
    logic        sel;
    logic        en_q;
    logic        seq_q;
    logic        ctx_q;
    logic        err_q;
    logic [31:0] dout_q;

    // prio holds the slot favoured when both are full (the one not sent last).
    always_comb begin
        sel = 1'b0;
        if (full[1])
            sel = full[0] ? prio : 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (bus.in_wr_en && !full[bus.in_ctx_num])
            mem[bus.in_ctx_num][wr_cnt[bus.in_ctx_num]] <= bus.in_din;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= IDLE;
            full    <= '0;
            seq_lat <= '0;
            wr_cnt  <= '{default: '0};
            err_q   <= 1'b0;
            rd_cnt  <= '0;
            rd_idx  <= '0;
            rd_pend <= 1'b0;
            slot    <= 1'b0;
            prio    <= 1'b0;
            en_q    <= 1'b0;
            seq_q   <= 1'b0;
            ctx_q   <= 1'b0;
        end else begin
            if (bus.in_wr_en) begin
                if (full[bus.in_ctx_num]) begin
                    err_q <= 1'b1;
                end else begin
                    if (wr_cnt[bus.in_ctx_num] == '0)
                        seq_lat[bus.in_ctx_num] <= bus.in_seq_num;
                    if (wr_cnt[bus.in_ctx_num] == LAST) begin
                        wr_cnt[bus.in_ctx_num] <= '0;
                        full[bus.in_ctx_num]   <= 1'b1;
                    end else begin
                        wr_cnt[bus.in_ctx_num] <= wr_cnt[bus.in_ctx_num] + 1'b1;
                    end
                end
            end

            en_q    <= 1'b0;
            rd_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if ((|full) && bus.tx_ready) begin
                        slot    <= sel;
                        ctx_q   <= sel;
                        seq_q   <= seq_lat[sel];
                        en_q    <= 1'b1;
                        rd_pend <= 1'b1;
                        rd_idx  <= '0;
                        rd_cnt  <= cnt_t'(1);
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        en_q    <= 1'b1;
                        rd_pend <= 1'b1;
                        rd_idx  <= rd_cnt;
                        rd_cnt  <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST) begin
                            full[slot] <= 1'b0;
                            prio       <= ~slot;
                            state      <= GAP;
                        end
                    end
                end
                GAP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // slot is stable for the whole burst, including the cycle after the last beat.
    always_ff @(posedge CLK) begin
        if (reset)
            dout_q <= '0;
        else if (rd_pend)
            dout_q <= mem[slot][rd_idx];
    end

    assign bus.in_full      = full;
    assign bus.dout_en      = en_q;
    assign bus.dout         = dout_q;
    assign bus.dout_seq_num = seq_q;
    assign bus.dout_ctx_num = ctx_q;
    assign bus.busy         = (state != IDLE);
    assign bus.err          = err_q;
endmodule
